// File: rtl/adc_buf_wr_ctrl.sv
// Buffer write controller: filters and formats ADC samples, writes them into a linear or circular window.
// Define ADC_BUF_WR_TRIG_EN to build in the ARMED state (start on a trigger channel).
module adc_buf_wr_ctrl #(
  parameter int ADC_NUM_CHS    = 8,
  parameter int ADC_CHID_WIDTH = 4,
  parameter int BUF_AWIDTH     = 10,
  parameter int BUF_TRANS_SIZE = 10
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [BUF_AWIDTH-1:0]     cfg_buf_startaddr_i,
  input  logic [BUF_TRANS_SIZE-1:0] cfg_buf_size_i,
  input  logic [BUF_TRANS_SIZE-1:0] cfg_buf_flevel_i,
  input  logic                      cfg_buf_continuous_i,
  input  logic                      cfg_buf_en_i,
  input  logic                      cfg_buf_clr_i,
  input  logic [ADC_NUM_CHS-1:0]    cfg_buf_ch_mask_i,
  input  logic                      cfg_buf_en_mode_i,
  input  logic [ADC_CHID_WIDTH-1:0] cfg_buf_en_chid_i,
  input  logic [1:0]                cfg_data_mask_mode_i,
  output logic                      cfg_buf_en_o,
  output logic [BUF_AWIDTH-1:0]     cfg_buf_curr_addr_o,
  output logic [BUF_TRANS_SIZE-1:0] cfg_buf_bytes_left_o,
  input  logic                      adc_valid_i,
  input  logic [ADC_CHID_WIDTH-1:0] adc_chid_i,
  input  logic [31:0]               adc_data_i,
  output logic                      buf_we_o,
  output logic [BUF_AWIDTH-1:0]     buf_addr_o,
  output logic [31:0]               buf_wdata_o,
  output logic                      flevel_evt_o,
  output logic                      done_evt_o
);

  localparam logic [BUF_AWIDTH-1:0]     ADDR_ONE = {{(BUF_AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [BUF_TRANS_SIZE-1:0] CNT_ONE  = {{(BUF_TRANS_SIZE-1){1'b0}}, 1'b1};

`ifdef ADC_BUF_WR_TRIG_EN
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  logic                      en_mode_q;
  logic [ADC_CHID_WIDTH-1:0] en_chid_q;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
  logic unused_trig;
  assign unused_trig = ^{cfg_buf_en_mode_i, cfg_buf_en_chid_i};
`endif

  state_t                    state_q, state_d;
  logic [BUF_AWIDTH-1:0]     start_q, curr_q, curr_d, addr_q;
  logic [BUF_TRANS_SIZE-1:0] size_q, flevel_q, left_q, left_d, written;
  logic                      cont_q;
  logic                      we_q, we_d, flevel_evt_q, flevel_d, done_evt_q, done_d;
  logic [31:0]               wdata_q, fmt_data;
  logic [3:0]                chid4;
  logic [15:0]               mask_ext;
  logic                      accept, wr, en_fire;

  assign chid4    = 4'(adc_chid_i);
  assign mask_ext = 16'(cfg_buf_ch_mask_i);
  assign accept   = adc_valid_i && (32'(chid4) < 32'(ADC_NUM_CHS)) && mask_ext[chid4];
  assign en_fire  = cfg_buf_en_i && !cfg_buf_clr_i && (state_q == IDLE) && (cfg_buf_size_i != '0);
  assign written  = size_q - left_q + CNT_ONE;

  always_comb begin
    fmt_data = adc_data_i;
    case (cfg_data_mask_mode_i)
      2'b01:   fmt_data = {16'h0, adc_data_i[15:0]};
      2'b10:   fmt_data = {chid4, adc_data_i[27:0]};
      2'b11:   fmt_data = {chid4, 12'h0, adc_data_i[15:0]};
      default: fmt_data = adc_data_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    curr_d   = curr_q;
    left_d   = left_q;
    we_d     = 1'b0;
    flevel_d = 1'b0;
    done_d   = 1'b0;
    wr       = 1'b0;
    case (state_q)
`ifdef ADC_BUF_WR_TRIG_EN
      ARMED:   wr = accept && (adc_chid_i == en_chid_q);
`endif
      RUN:     wr = accept;
      default: wr = 1'b0;
    endcase
    if (cfg_buf_clr_i) begin
      state_d = IDLE;
      curr_d  = start_q;
      left_d  = '0;
    end else if (en_fire) begin
      curr_d  = cfg_buf_startaddr_i;
      left_d  = cfg_buf_size_i;
`ifdef ADC_BUF_WR_TRIG_EN
      state_d = cfg_buf_en_mode_i ? ARMED : RUN;
`else
      state_d = RUN;
`endif
    end else if (wr) begin
      // The trigger sample itself is written, so ARMED enters RUN through the write path.
      state_d  = RUN;
      we_d     = 1'b1;
      curr_d   = curr_q + ADDR_ONE;
      left_d   = left_q - CNT_ONE;
      flevel_d = (flevel_q != '0) && (written == flevel_q);
      if (left_q == CNT_ONE) begin
        done_d = 1'b1;
        if (cont_q) begin
          curr_d = start_q;
          left_d = size_q;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      start_q      <= '0;
      size_q       <= '0;
      flevel_q     <= '0;
      cont_q       <= 1'b0;
      curr_q       <= '0;
      left_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      flevel_evt_q <= 1'b0;
      done_evt_q   <= 1'b0;
`ifdef ADC_BUF_WR_TRIG_EN
      en_mode_q    <= 1'b0;
      en_chid_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      curr_q       <= curr_d;
      left_q       <= left_d;
      we_q         <= we_d;
      flevel_evt_q <= flevel_d;
      done_evt_q   <= done_d;
      if (en_fire) begin
        start_q   <= cfg_buf_startaddr_i;
        size_q    <= cfg_buf_size_i;
        flevel_q  <= cfg_buf_flevel_i;
        cont_q    <= cfg_buf_continuous_i;
`ifdef ADC_BUF_WR_TRIG_EN
        en_mode_q <= cfg_buf_en_mode_i;
        en_chid_q <= cfg_buf_en_chid_i;
`endif
      end
      if (we_d) begin
        addr_q  <= curr_q;
        wdata_q <= fmt_data;
      end
    end
  end

  assign cfg_buf_en_o         = (state_q != IDLE);
  assign cfg_buf_curr_addr_o  = curr_q;
  assign cfg_buf_bytes_left_o = left_q;
  assign buf_we_o             = we_q;
  assign buf_addr_o           = addr_q;
  assign buf_wdata_o          = wdata_q;
  assign flevel_evt_o         = flevel_evt_q;
  assign done_evt_o           = done_evt_q;

endmodule

// File: tb/tb_adc_buf_wr_ctrl.sv
// Scoreboard bench for adc_buf_wr_ctrl; expected writes are queued with stimulus and checked per write.
module tb_adc_buf_wr_ctrl;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [9:0]  cfg_buf_startaddr_i;
  logic [9:0]  cfg_buf_size_i;
  logic [9:0]  cfg_buf_flevel_i;
  logic        cfg_buf_continuous_i;
  logic        cfg_buf_en_i;
  logic        cfg_buf_clr_i;
  logic [7:0]  cfg_buf_ch_mask_i;
  logic        cfg_buf_en_mode_i;
  logic [3:0]  cfg_buf_en_chid_i;
  logic [1:0]  cfg_data_mask_mode_i;
  logic        cfg_buf_en_o;
  logic [9:0]  cfg_buf_curr_addr_o;
  logic [9:0]  cfg_buf_bytes_left_o;
  logic        adc_valid_i;
  logic [3:0]  adc_chid_i;
  logic [31:0] adc_data_i;
  logic        buf_we_o;
  logic [9:0]  buf_addr_o;
  logic [31:0] buf_wdata_o;
  logic        flevel_evt_o;
  logic        done_evt_o;

  always #5 clk = ~clk;

  adc_buf_wr_ctrl #(
    .ADC_NUM_CHS(8),
    .ADC_CHID_WIDTH(4),
    .BUF_AWIDTH(10),
    .BUF_TRANS_SIZE(10)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn_i),
    .cfg_buf_startaddr_i(cfg_buf_startaddr_i),
    .cfg_buf_size_i(cfg_buf_size_i),
    .cfg_buf_flevel_i(cfg_buf_flevel_i),
    .cfg_buf_continuous_i(cfg_buf_continuous_i),
    .cfg_buf_en_i(cfg_buf_en_i),
    .cfg_buf_clr_i(cfg_buf_clr_i),
    .cfg_buf_ch_mask_i(cfg_buf_ch_mask_i),
    .cfg_buf_en_mode_i(cfg_buf_en_mode_i),
    .cfg_buf_en_chid_i(cfg_buf_en_chid_i),
    .cfg_data_mask_mode_i(cfg_data_mask_mode_i),
    .cfg_buf_en_o(cfg_buf_en_o),
    .cfg_buf_curr_addr_o(cfg_buf_curr_addr_o),
    .cfg_buf_bytes_left_o(cfg_buf_bytes_left_o),
    .adc_valid_i(adc_valid_i),
    .adc_chid_i(adc_chid_i),
    .adc_data_i(adc_data_i),
    .buf_we_o(buf_we_o),
    .buf_addr_o(buf_addr_o),
    .buf_wdata_o(buf_wdata_o),
    .flevel_evt_o(flevel_evt_o),
    .done_evt_o(done_evt_o)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        fl;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (buf_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write", buf_addr_o, buf_wdata_o);
        end else begin
          mon_e = exp_q.pop_front();
          if ({buf_addr_o, buf_wdata_o, flevel_evt_o, done_evt_o} !== mon_e) begin
            n_fail++;
            $display("FAIL write: got addr=%h data=%h fl=%b done=%b, required addr=%h data=%h fl=%b done=%b",
                     buf_addr_o, buf_wdata_o, flevel_evt_o, done_evt_o,
                     mon_e.addr, mon_e.data, mon_e.fl, mon_e.dn);
          end
        end
      end else if ({buf_we_o, flevel_evt_o, done_evt_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_outputs: got we=%b fl=%b done=%b, required 000", buf_we_o, flevel_evt_o, done_evt_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [9:0] start, input logic [9:0] size, input logic [9:0] fl,
                         input logic cont, input logic [7:0] mask, input logic [1:0] mode,
                         input logic en_mode, input logic [3:0] chid);
    cfg_buf_startaddr_i  = start;
    cfg_buf_size_i       = size;
    cfg_buf_flevel_i     = fl;
    cfg_buf_continuous_i = cont;
    cfg_buf_ch_mask_i    = mask;
    cfg_data_mask_mode_i = mode;
    cfg_buf_en_mode_i    = en_mode;
    cfg_buf_en_chid_i    = chid;
  endtask

  task automatic pulse_en();
    cfg_buf_en_i = 1'b1;
    tick();
    cfg_buf_en_i = 1'b0;
  endtask

  task automatic pulse_clr();
    cfg_buf_clr_i = 1'b1;
    tick();
    cfg_buf_clr_i = 1'b0;
  endtask

  task automatic sample(input logic [3:0] ch, input logic [31:0] d);
    adc_valid_i = 1'b1;
    adc_chid_i  = ch;
    adc_data_i  = d;
    tick();
    adc_valid_i = 1'b0;
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [31:0] d, input logic fl, input logic dn);
    exp_q.push_back({a, d, fl, dn});
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o, buf_we_o, buf_addr_o,
         buf_wdata_o, flevel_evt_o, done_evt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset: got en=%b curr=%h left=%0d we=%b addr=%h data=%h fl=%b done=%b, required all 0",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o, buf_we_o, buf_addr_o,
               buf_wdata_o, flevel_evt_o, done_evt_o);
    end
    rstn_i = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_linear();
    set_cfg(10'h010, 10'd4, 10'd0, 1'b0, 8'hFF, 2'b00, 1'b0, 4'd0);
    pulse_en();
    n_checks++;
    if (cfg_buf_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL linear_en_rise: got %b, required 1", cfg_buf_en_o);
    end
    for (int k = 0; k < 4; k++) begin
      expect_wr(10'h010 + 10'(k), 32'hA000_0000 + 32'(k), 1'b0, k == 3);
      sample(4'd0, 32'hA000_0000 + 32'(k));
    end
    repeat (2) tick();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {1'b0, 10'h014, 10'd0}) begin
      n_fail++;
      $display("FAIL linear_status: got en=%b curr=%h left=%0d, required en=0 curr=014 left=0",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL linear_drain: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_circular();
    set_cfg(10'h000, 10'd3, 10'd2, 1'b1, 8'hFF, 2'b00, 1'b0, 4'd0);
    pulse_en();
    for (int k = 1; k <= 7; k++) begin
      expect_wr(10'((k - 1) % 3), 32'h1000 + 32'(k), (k == 2) || (k == 5), (k == 3) || (k == 6));
      sample(4'd5, 32'h1000 + 32'(k));
    end
    repeat (2) tick();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {1'b1, 10'h001, 10'd2}) begin
      n_fail++;
      $display("FAIL circular_status: got en=%b curr=%h left=%0d, required en=1 curr=001 left=2",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
    pulse_clr();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {1'b0, 10'h000, 10'd0}) begin
      n_fail++;
      $display("FAIL circular_clr: got en=%b curr=%h left=%0d, required en=0 curr=000 left=0",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL circular_drain: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mask_format();
    logic [1:0]  modes [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [31:0] exp_d [8] = '{32'hABCD1234, 32'hABCD1234, 32'h0BCD1234, 32'h2BCD1234,
                               32'h00001234, 32'h20001234, 32'h00001234, 32'h00001234};
    set_cfg(10'h100, 10'd8, 10'd0, 1'b0, 8'h05, 2'b00, 1'b0, 4'd0);
    pulse_en();
    for (int i = 0; i < 8; i++)
      expect_wr(10'h100 + 10'(i), exp_d[i], 1'b0, i == 7);
    for (int m = 0; m < 4; m++) begin
      cfg_data_mask_mode_i = modes[m];
      for (int ch = 0; ch < 4; ch++)
        sample(4'(ch), 32'hABCD1234);
    end
    repeat (2) tick();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {1'b0, 10'h108, 10'd0}) begin
      n_fail++;
      $display("FAIL mask_status: got en=%b curr=%h left=%0d, required en=0 curr=108 left=0",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mask_drain: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_trigger();
    logic [3:0] chs [4] = '{4'd1, 4'd2, 4'd3, 4'd1};
    set_cfg(10'h020, 10'd8, 10'd0, 1'b0, 8'hFF, 2'b00, 1'b1, 4'd3);
    pulse_en();
    n_checks++;
    if (cfg_buf_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL trigger_en: got %b, required 1", cfg_buf_en_o);
    end
`ifdef ADC_BUF_WR_TRIG_EN
    expect_wr(10'h020, 32'hD000_0002, 1'b0, 1'b0);
    expect_wr(10'h021, 32'hD000_0003, 1'b0, 1'b0);
`else
    for (int i = 0; i < 4; i++)
      expect_wr(10'h020 + 10'(i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
`endif
    for (int i = 0; i < 4; i++)
      sample(chs[i], 32'hD000_0000 + 32'(i));
    repeat (2) tick();
    n_checks++;
`ifdef ADC_BUF_WR_TRIG_EN
    if ({cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {10'h022, 10'd6}) begin
      n_fail++;
      $display("FAIL trigger_status: got curr=%h left=%0d, required curr=022 left=6",
               cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
`else
    if ({cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {10'h024, 10'd4}) begin
      n_fail++;
      $display("FAIL trigger_status: got curr=%h left=%0d, required curr=024 left=4",
               cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
`endif
    pulse_clr();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o} !== {1'b0, 10'h020}) begin
      n_fail++;
      $display("FAIL trigger_clr: got en=%b curr=%h, required en=0 curr=020", cfg_buf_en_o, cfg_buf_curr_addr_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL trigger_drain: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clear_edges();
    set_cfg(10'h040, 10'd4, 10'd0, 1'b0, 8'hFF, 2'b00, 1'b0, 4'd0);
    pulse_en();
    expect_wr(10'h040, 32'h5555_0001, 1'b0, 1'b0);
    sample(4'd1, 32'h5555_0001);
    cfg_buf_clr_i = 1'b1;
    sample(4'd1, 32'h5555_0002);
    cfg_buf_clr_i = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {1'b0, 10'h040, 10'd0}) begin
      n_fail++;
      $display("FAIL clr_with_sample: got en=%b curr=%h left=%0d, required en=0 curr=040 left=0",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
    cfg_buf_en_i  = 1'b1;
    cfg_buf_clr_i = 1'b1;
    tick();
    cfg_buf_en_i  = 1'b0;
    cfg_buf_clr_i = 1'b0;
    n_checks++;
    if (cfg_buf_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_over_en: got en=%b, required 0", cfg_buf_en_o);
    end
    cfg_buf_size_i      = 10'd0;
    cfg_buf_startaddr_i = 10'h155;
    pulse_en();
    sample(4'd0, 32'h5555_0003);
    tick();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {1'b0, 10'h040, 10'd0}) begin
      n_fail++;
      $display("FAIL size_zero: got en=%b curr=%h left=%0d, required en=0 curr=040 left=0",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clear_drain: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    logic [9:0] addrs [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    set_cfg(10'h3FE, 10'd4, 10'd4, 1'b0, 8'hFF, 2'b00, 1'b0, 4'd0);
    pulse_en();
    for (int k = 0; k < 4; k++) begin
      expect_wr(addrs[k], 32'hC0DE_0000 + 32'(k), k == 3, k == 3);
      if (k == 1) begin
        cfg_buf_en_i        = 1'b1;
        cfg_buf_startaddr_i = 10'h000;
      end
      sample(4'd7, 32'hC0DE_0000 + 32'(k));
      cfg_buf_en_i = 1'b0;
    end
    repeat (2) tick();
    n_checks++;
    if ({cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o} !== {1'b0, 10'h002, 10'd0}) begin
      n_fail++;
      $display("FAIL wrap_status: got en=%b curr=%h left=%0d, required en=0 curr=002 left=0",
               cfg_buf_en_o, cfg_buf_curr_addr_o, cfg_buf_bytes_left_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_drain: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rstn_i        = 1'b0;
    cfg_buf_en_i  = 1'b0;
    cfg_buf_clr_i = 1'b0;
    adc_valid_i   = 1'b0;
    adc_chid_i    = '0;
    adc_data_i    = '0;
    set_cfg(10'h000, 10'd0, 10'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0);
    test_reset();
    test_linear();
    test_circular();
    test_mask_format();
    test_trigger();
    test_clear_edges();
    test_wrap();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_buf_wr_ctrl.md
# adc_buf_wr_ctrl

Buffer write controller directly downstream of the ADC register interface. It consumes the `cfg_buf_*` configuration and the one-shot enable/clear pulses, filters the incoming ADC sample stream by channel mask, and formats each accepted sample. It writes samples into the local sample buffer as a linear or circular window, and returns the status values the register interface reads back: active flag, current address and words left. It also raises fill-level and done event pulses.

## Interface
Parameters:
- ADC_NUM_CHS, 8, number of ADC channels.
- ADC_CHID_WIDTH, 4, channel ID width; must be ≥ clog2(ADC_NUM_CHS) and ≤ 4.
- BUF_AWIDTH, 10, buffer word-address width.
- BUF_TRANS_SIZE, 10, transfer size width, in words.

Ports:
- clk_i, in, 1: single clock.
- rstn_i, in, 1: reset, synchronous, active-low.
- cfg_buf_startaddr_i, in, BUF_AWIDTH: window start word address.
- cfg_buf_size_i, in, BUF_TRANS_SIZE: window length in words.
- cfg_buf_flevel_i, in, BUF_TRANS_SIZE: fill-level event threshold; 0 disables the event.
- cfg_buf_continuous_i, in, 1: selects circular mode.
- cfg_buf_en_i, in, 1: enable pulse.
- cfg_buf_clr_i, in, 1: clear/abort pulse.
- cfg_buf_ch_mask_i, in, ADC_NUM_CHS: channel accept mask.
- cfg_buf_en_mode_i, in, 1: 1 = arm, then start on a trigger channel.
- cfg_buf_en_chid_i, in, ADC_CHID_WIDTH: trigger channel ID.
- cfg_data_mask_mode_i, in, 2: output data format.
- cfg_buf_en_o, out, 1: high while ARMED or RUN.
- cfg_buf_curr_addr_o, out, BUF_AWIDTH: next write address.
- cfg_buf_bytes_left_o, out, BUF_TRANS_SIZE: words remaining in the current pass.
- adc_valid_i, in, 1: sample strobe; no backpressure.
- adc_chid_i, in, ADC_CHID_WIDTH: sample channel ID.
- adc_data_i, in, 32: sample data.
- buf_we_o, out, 1: buffer write enable.
- buf_addr_o, out, BUF_AWIDTH: buffer write address.
- buf_wdata_o, out, 32: buffer write data.
- flevel_evt_o, out, 1: one-cycle pulse on reaching the fill level.
- done_evt_o, out, 1: one-cycle pulse on completing a pass.

## Operation
- States: IDLE, ARMED, RUN. Reset forces IDLE; every output is 0.
- IDLE + en pulse with cfg_buf_size_i ≠ 0:
  - latch start, size, flevel, continuous, en_mode and en_chid;
  - set curr = start, left = size;
  - go to ARMED if en_mode = 1, otherwise RUN.
- IDLE + en pulse with size = 0: ignored.
- en pulse in ARMED or RUN: ignored.
- clr pulse in any state:
  - go to IDLE, set curr = latched start, left = 0, no write;
  - clr wins over a simultaneous en and over a simultaneous sample.
- Sample acceptance: adc_valid_i && adc_chid_i < ADC_NUM_CHS && cfg_buf_ch_mask_i[adc_chid_i].
  - ch_mask and mask_mode are used live, not latched.
- ARMED: an accepted sample with chid == latched en_chid moves the FSM to RUN, and that same sample is written. All other samples are dropped.
- RUN: each accepted sample is written at curr; then curr++ and left--.
- Data format, by mask mode:
  - 00: adc_data_i unchanged.
  - 01: {16'h0, data[15:0]}.
  - 10: {chid zero-extended to 4 bits, data[27:0]}.
  - 11: {chid zero-extended to 4 bits, 12'h0, data[15:0]}.
- Fill-level event: flevel_evt_o pulses when the write takes the written-word count (size − left) to flevel. It fires at most once per pass; flevel > size never fires.
- Last word of a pass (left 1→0):
  - done_evt_o pulses;
  - continuous: curr = start, left = size, stay in RUN;
  - otherwise: go to IDLE, curr holds start + size (wrapping mod 2^BUF_AWIDTH), left = 0.
- Address arithmetic is modulo 2^BUF_AWIDTH; a window crossing the top of memory wraps to 0.

## Timing
- A sample accepted at cycle N drives buf_we_o, buf_addr_o and buf_wdata_o, registered, at cycle N+1.
- Throughput: one sample per cycle, back-to-back.
- Status outputs and both event pulses change at N+1, aligned with buf_we_o.
- cfg_buf_en_o rises the cycle after the en pulse, and falls the cycle after the final write or after clr.
- In IDLE, cfg_buf_curr_addr_o holds its last value.
- buf_addr_o and buf_wdata_o are don't-care when buf_we_o = 0, but are held stable.

## Configuration
- `ADC_BUF_WR_TRIG_EN` defined: ARMED state and trigger logic are present, behaving as described above.
- Not defined:
  - no ARMED state; cfg_buf_en_mode_i and cfg_buf_en_chid_i are ignored;
  - an en pulse always goes IDLE→RUN.

## Test plan
- Linear pass: start = 0x010, size = 4, mask 0xFF, 4 samples on ch0 → writes at 0x010..0x013; done at the 4th write; cfg_buf_en_o = 0; curr = 0x014; left = 0.
- Circular pass with fill level: size = 3, flevel = 2, continuous, 7 samples → addresses 0,1,2,0,1,2,0; flevel pulses on writes 2 and 5; done pulses on writes 3 and 6; left = 2 at end.
- Channel mask and formats: mask = 0x05, samples on ch0..ch3 with data 0xABCD1234.
  - Only ch0 and ch2 are written.
  - mode 10 gives 0x2BCD1234 for ch2; mode 11 gives 0x20001234.
- Trigger (macro on): en_mode = 1, chid = 3, samples ch1, ch2, ch3, ch1 → first write is the ch3 sample at start, second is ch1. With the macro off, all 4 are written.
- Clear and edge cases:
  - clr in the same cycle as a sample → no write, IDLE, curr = start;
  - en with size = 0 → stays IDLE;
  - start = 0x3FE, size = 4 → writes 0x3FE, 0x3FF, 0x000, 0x001.
